// File: rtl/fetch_unit.sv
// Instruction fetch unit: fetches cache lines over a tagged request/response bus and streams
// 64-bit instruction pairs to the decoder. Define FETCH_TRACE_EN to print every transfer.
module fetch_unit #(
    parameter int          LINE_BEATS = 8,
    parameter logic [12:0] REQTAG     = 13'h1100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] entry,
    output logic        bus_reqcyc,
    input  logic        bus_reqack,
    output logic [63:0] bus_req,
    output logic [12:0] bus_reqtag,
    input  logic        bus_respcyc,
    input  logic [63:0] bus_resp,
    input  logic [12:0] bus_resptag,
    output logic        bus_respack,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic [63:0] instruction_full,
    output logic [63:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready
);
    localparam int IDX_W = $clog2(LINE_BEATS);
    localparam int CNT_W = IDX_W + 1;
    localparam int OFF_W = IDX_W + 3;
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(LINE_BEATS - 1);
    localparam logic [63:0]      LINE_BYTES = 64'(LINE_BEATS * 8);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DRAIN} state_t;

    state_t           state_reg;
    logic [63:0]      pc_reg;
    logic [63:0]      pend_pc_reg;
    logic             pend_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] rd_idx_reg;
    logic [63:0]      line_buf [LINE_BEATS];

    logic [63:0] line_base;
    logic        store;
    logic        last_store;
    logic        deliver;
    logic        xfer;
    logic        pc_lsb_unused;

    assign line_base     = {pc_reg[63:OFF_W], {OFF_W{1'b0}}};
    assign pc_lsb_unused = ^pc_reg[2:0];

    assign bus_reqcyc  = !reset && (state_reg == REQ);
    assign bus_req     = bus_reqcyc ? line_base : '0;
    assign bus_reqtag  = REQTAG;
    assign bus_respack = !reset && (state_reg == RESP) && bus_respcyc;

    // Foreign-tag beats are acked but never stored.
    assign store      = bus_respack && (bus_resptag == REQTAG);
    assign last_store = store && (cnt_reg == LAST_BEAT);

    assign deliver = !reset && (state_reg == RESP || state_reg == DRAIN) && !pend_reg
                     && (rd_idx_reg < cnt_reg);
    assign xfer    = deliver && instr_ready;

    assign instr_valid      = deliver;
    assign instr_pc         = deliver ? line_base + (64'(rd_idx_reg) << 3) : '0;
    assign instruction_full = deliver ? line_buf[rd_idx_reg[IDX_W-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (store) begin
            line_buf[cnt_reg[IDX_W-1:0]] <= bus_resp;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            pc_reg      <= entry;
            pend_reg    <= 1'b0;
            pend_pc_reg <= '0;
            cnt_reg     <= '0;
            rd_idx_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (redirect_valid) begin
                        pc_reg <= redirect_pc;
                    end
                    cnt_reg   <= '0;
                    state_reg <= REQ;
                end
                REQ: begin
                    // The request stays up unchanged; a redirect here only takes effect after the burst.
                    if (redirect_valid) begin
                        pend_reg    <= 1'b1;
                        pend_pc_reg <= redirect_pc;
                    end
                    if (bus_reqack) begin
                        cnt_reg    <= '0;
                        rd_idx_reg <= CNT_W'(pc_reg[OFF_W-1:3]);
                        state_reg  <= RESP;
                    end
                end
                RESP: begin
                    if (store) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                    if (xfer) begin
                        rd_idx_reg <= rd_idx_reg + CNT_W'(1);
                    end
                    if (last_store) begin
                        if (redirect_valid || pend_reg) begin
                            pc_reg    <= redirect_valid ? redirect_pc : pend_pc_reg;
                            pend_reg  <= 1'b0;
                            cnt_reg   <= '0;
                            state_reg <= REQ;
                        end else begin
                            state_reg <= DRAIN;
                        end
                    end else if (redirect_valid) begin
                        pend_reg    <= 1'b1;
                        pend_pc_reg <= redirect_pc;
                    end
                end
                DRAIN: begin
                    if (redirect_valid) begin
                        pc_reg    <= redirect_pc;
                        cnt_reg   <= '0;
                        state_reg <= REQ;
                    end else if (xfer) begin
                        rd_idx_reg <= rd_idx_reg + CNT_W'(1);
                        if (rd_idx_reg == LAST_BEAT) begin
                            pc_reg    <= line_base + LINE_BYTES;
                            cnt_reg   <= '0;
                            state_reg <= REQ;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef FETCH_TRACE_EN
    always_ff @(posedge clk) begin
        if (xfer) begin
            $display("FETCH pc=%h insn=%h", instr_pc, instruction_full);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected bus requests and decoder words
// into queues; a negedge monitor pops and compares whenever the DUT hands something over.
module tb_fetch_unit;
    localparam logic [12:0] TAG = 13'h1100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] entry = '0;
    logic        bus_reqcyc;
    logic        bus_reqack = 1'b0;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_respcyc = 1'b0;
    logic [63:0] bus_resp = '0;
    logic [12:0] bus_resptag = '0;
    logic        bus_respack;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic [63:0] instruction_full;
    logic [63:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] data;
    } instr_t;

    instr_t      exp_instr[$];
    logic [63:0] exp_req[$];
    instr_t      mon_e;
    logic [63:0] mon_a;

    fetch_unit dut (
        .clk(clk), .reset(reset), .entry(entry),
        .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack), .bus_req(bus_req),
        .bus_reqtag(bus_reqtag), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
        .bus_resptag(bus_resptag), .bus_respack(bus_respack),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instruction_full(instruction_full), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    function automatic logic [63:0] beat(input int k, input int i);
        return {16'hDA7A, 16'(k), 24'h0, 8'(i)};
    endfunction

    // Monitor: bus requests and decoder transfers
    always @(negedge clk) begin
        if (!reset && bus_reqcyc && bus_reqack) begin
            tests++;
            if (exp_req.size() == 0) begin
                fails++;
                $display("FAIL unexpected_req: got %h, required no request", bus_req);
            end else begin
                mon_a = exp_req.pop_front();
                if (bus_req !== mon_a || bus_reqtag !== TAG) begin
                    fails++;
                    $display("FAIL bus_req: got %h tag %h, required %h tag %h",
                             bus_req, bus_reqtag, mon_a, TAG);
                end else begin
                    $display("[TB] req %h ok", bus_req);
                end
            end
        end
        if (!reset && instr_valid && instr_ready) begin
            tests++;
            if (exp_instr.size() == 0) begin
                fails++;
                $display("FAIL unexpected_instr: got pc=%h data=%h, required no transfer",
                         instr_pc, instruction_full);
            end else begin
                mon_e = exp_instr.pop_front();
                if (instr_pc !== mon_e.pc || instruction_full !== mon_e.data) begin
                    fails++;
                    $display("FAIL instr: got pc=%h data=%h, required pc=%h data=%h",
                             instr_pc, instruction_full, mon_e.pc, mon_e.data);
                end else begin
                    $display("[TB] xfer pc=%h data=%h ok", instr_pc, instruction_full);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end else begin
            $display("[TB] %s = %h ok", name, got);
        end
    endtask

    task automatic push_line(input int k, input logic [63:0] base, input int first);
        instr_t t;
        for (int i = first; i < 8; i++) begin
            t.pc   = base + 64'(8 * i);
            t.data = beat(k, i);
            exp_instr.push_back(t);
        end
    endtask

    task automatic do_reset(input logic [63:0] e);
        reset = 1'b1;
        entry = e;
        bus_reqack = 1'b0;
        bus_respcyc = 1'b0;
        redirect_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_reqcyc", 64'(bus_reqcyc), 64'd0);
        check("rst_respack", 64'(bus_respack), 64'd0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_bus_req", bus_req, 64'd0);
        check("rst_instr_full", instruction_full, 64'd0);
        check("rst_instr_pc", instr_pc, 64'd0);
        reset = 1'b0;
    endtask

    // Acks the request on the first cycle it is visible.
    task automatic serve_req();
        int n = 0;
        while (!bus_reqcyc && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus_reqcyc) begin
            tests++;
            fails++;
            $display("FAIL req_timeout: got no bus_reqcyc, required a request");
        end else begin
            bus_reqack = 1'b1;
            @(posedge clk); #1;
            bus_reqack = 1'b0;
        end
    endtask

    task automatic send_beats(input int k, input int first, input int n, input int bad_at,
                              input bit quiet);
        for (int i = first; i < first + n; i++) begin
            if (i == bad_at) begin
                bus_respcyc = 1'b1;
                bus_resp    = 64'hBAD0_BAD0_BAD0_BAD0;
                bus_resptag = 13'h0000;
                #1;
                check("respack_foreign", 64'(bus_respack), 64'd1);
                @(posedge clk); #1;
            end
            bus_respcyc = 1'b1;
            bus_resp    = beat(k, i);
            bus_resptag = TAG;
            #1;
            check("respack", 64'(bus_respack), 64'd1);
            if (quiet) check("quiet_valid", 64'(instr_valid), 64'd0);
            @(posedge clk); #1;
        end
        bus_respcyc = 1'b0;
    endtask

    task automatic pulse_redirect(input logic [63:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
    endtask

    task automatic wait_drained(input string name);
        int n = 0;
        while (exp_instr.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_left"}, 64'(exp_instr.size()), 64'd0);
    endtask

    initial begin
        int n;

        // Aligned entry: full line then the next line
        instr_ready = 1'b1;
        do_reset(64'h1000);
        exp_req.push_back(64'h1000);
        push_line(1, 64'h1000, 0);
        serve_req();
        send_beats(1, 0, 8, -1, 1'b0);
        wait_drained("s1");
        exp_req.push_back(64'h1040);
        serve_req();

        // Mid-line entry: only beats 5..7 delivered
        do_reset(64'h1028);
        exp_req.push_back(64'h1000);
        push_line(2, 64'h1000, 5);
        serve_req();
        send_beats(2, 0, 8, -1, 1'b0);
        wait_drained("s2");
        exp_req.push_back(64'h1040);
        serve_req();

        // Redirects during RESP; the second overwrites the first
        do_reset(64'h1038);
        exp_req.push_back(64'h1000);
        serve_req();
        send_beats(3, 0, 3, -1, 1'b0);
        pulse_redirect(64'h3000);
        send_beats(3, 3, 2, -1, 1'b1);
        pulse_redirect(64'h2000);
        send_beats(3, 5, 3, -1, 1'b1);
        exp_req.push_back(64'h2000);
        push_line(4, 64'h2000, 0);
        serve_req();
        send_beats(4, 0, 8, -1, 1'b0);
        wait_drained("s3");

        // Decoder stall on the last beat in DRAIN
        instr_ready = 1'b0;
        do_reset(64'h1000);
        exp_req.push_back(64'h1000);
        push_line(5, 64'h1000, 0);
        serve_req();
        send_beats(5, 0, 8, -1, 1'b0);
        instr_ready = 1'b1;
        n = 0;
        while (exp_instr.size() > 1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        instr_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_valid", 64'(instr_valid), 64'd1);
            check("stall_pc", instr_pc, 64'h1038);
            check("stall_data", instruction_full, beat(5, 7));
            check("stall_reqcyc", 64'(bus_reqcyc), 64'd0);
        end
        @(posedge clk); #1;
        instr_ready = 1'b1;
        wait_drained("s4");
        exp_req.push_back(64'h1040);
        serve_req();

        // Foreign-tag beat mid-burst
        do_reset(64'h1000);
        exp_req.push_back(64'h1000);
        push_line(6, 64'h1000, 0);
        serve_req();
        send_beats(6, 0, 8, 4, 1'b0);
        wait_drained("s5");

        // Reset mid-RESP
        do_reset(64'h1000);
        exp_req.push_back(64'h1000);
        push_line(7, 64'h1000, 0);
        serve_req();
        send_beats(7, 0, 2, -1, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("mid_left", 64'(exp_instr.size()), 64'd6);
        exp_instr.delete();
        bus_respcyc = 1'b1;
        bus_resp    = beat(7, 2);
        bus_resptag = TAG;
        reset = 1'b1;
        entry = 64'h5678;
        @(posedge clk); #1;
        check("midrst_reqcyc", 64'(bus_reqcyc), 64'd0);
        check("midrst_respack", 64'(bus_respack), 64'd0);
        check("midrst_valid", 64'(instr_valid), 64'd0);
        do_reset(64'h5678);
        exp_req.push_back(64'h5640);
        push_line(8, 64'h5640, 7);
        serve_req();
        send_beats(8, 0, 8, -1, 1'b0);
        wait_drained("s6");

        // Top-of-memory line wraps to address 0
        do_reset(64'hFFFF_FFFF_FFFF_FFF8);
        exp_req.push_back(64'hFFFF_FFFF_FFFF_FFC0);
        push_line(9, 64'hFFFF_FFFF_FFFF_FFC0, 7);
        serve_req();
        send_beats(9, 0, 8, -1, 1'b0);
        wait_drained("s7");
        exp_req.push_back(64'h0);
        serve_req();

        check("req_left", 64'(exp_req.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter LINE_BEATS, default 8: 64-bit beats per cache-line burst (line = 64 bytes).
REQ-002 Parameter REQTAG, default 13'h1100: tag sent on every request: [12]=read, [11:8]=memory, [7:0]=0.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 entry  in  64  program entry PC, 8-byte aligned, sampled only while reset is high.
REQ-006 bus_reqcyc  out  1  request valid; bus_req and bus_reqtag held stable while high.
REQ-007 bus_reqack  in  1  request accepted by the bus.
REQ-008 bus_req  out  64  line-aligned fetch address.
REQ-009 bus_reqtag  out  13  request tag, equal to REQTAG.
REQ-010 bus_respcyc  in  1  response beat valid.
REQ-011 bus_resp  in  64  response beat data.
REQ-012 bus_resptag  in  13  response beat tag.
REQ-013 bus_respack  out  1  beat accepted.
REQ-014 redirect_valid  in  1  jump to redirect_pc; single-cycle pulse.
REQ-015 redirect_pc  in  64  new PC, 8-byte aligned.
REQ-016 instruction_full  out  64  two packed 32-bit instructions to the decoder; the lower word is at instr_pc.
REQ-017 instr_pc  out  64  address of instruction_full.
REQ-018 instr_valid  out  1  instruction_full and instr_pc are valid.
REQ-019 instr_ready  in  1  decoder accepts the word; a transfer occurs when valid and ready are both high.

Function
REQ-020 FSM states: IDLE, REQ, RESP, DRAIN; at most one outstanding bus request.
REQ-021 IDLE -> REQ unconditionally on the next edge.
REQ-022 REQ: bus_reqcyc=1, bus_req = pc & ~63; on bus_reqack=1 -> RESP.
REQ-023 RESP: bus_respack = bus_respcyc, combinationally, every cycle. Beats with bus_resptag==REQTAG are stored in beat order in a LINE_BEATS x 64 buffer; other beats are acked and discarded.
REQ-024 RESP -> DRAIN on the edge that stores beat LINE_BEATS-1.
REQ-025 First delivered beat index = pc[5:3]; earlier beats are stored but never presented.
REQ-026 instr_valid=1 when read index < stored-beat count and no redirect is pending; this is legal in RESP and DRAIN (zero-bubble delivery of already-stored beats).
REQ-027 instr_pc = line base + 8*read index; each transfer increments the read index.
REQ-028 DRAIN: transfer of beat LINE_BEATS-1 -> pc <= line base + 64, state REQ on the next edge.
REQ-029 Redirect in IDLE or DRAIN: pc <= redirect_pc, buffer flushed, instr_valid=0 next cycle, -> REQ; any transfer in the same cycle still counts as delivered.
REQ-030 Redirect in REQ or RESP: latch the pending redirect, hold the bus request stable, complete the burst with acks, suppress instr_valid, discard the data; after the last beat, pc <= pending PC, -> REQ.
REQ-031 A second redirect while one is pending overwrites the pending PC.
REQ-032 Address arithmetic is 64-bit modulo 2^64; the line at 64'hFFFF_FFFF_FFFF_FFC0 wraps to 0.
REQ-033 instr_valid stays high with instruction_full and instr_pc stable until a transfer or a redirect occurs.

Reset
REQ-034 With reset high at a clock edge: state IDLE, pc <= entry, buffer counts 0, pending redirect cleared.
REQ-035 Output values during and after reset: bus_reqcyc=0, bus_respack=0, instr_valid=0, bus_req=0, instruction_full=0, instr_pc=0.
REQ-036 Reset mid-burst abandons the transaction, because the bus is reset by the same signal.

Configuration
REQ-037 Macro FETCH_TRACE_EN: when defined, each transfer prints via $display "FETCH pc=<instr_pc hex> insn=<instruction_full hex>". When undefined, no display code is compiled; cycle behaviour is identical in both cases.

Verification
REQ-038 entry=0x1000, reset released, bus acks REQ on its 1st cycle, 8 beats D0..D7 back-to-back, instr_ready=1 -> bus_req=0x1000; words D0..D7 delivered with instr_pc 0x1000..0x1038; next bus_req=0x1040.
REQ-039 entry=0x1028 -> bus_req=0x1000; only D5,D6,D7 delivered, with instr_pc 0x1028,0x1030,0x1038.
REQ-040 Redirect to 0x2000 during RESP after 3 beats -> all 8 beats acked, no instr_valid from that line, next bus_req=0x2000.
REQ-041 instr_ready=0 for 5 cycles in DRAIN -> instr_valid, instr_pc and data held; no new bus_reqcyc until beat 7 is transferred.
REQ-042 Beat with bus_resptag=13'h0000 inserted mid-burst -> acked, not stored; burst completes only after 8 matching beats.
REQ-043 Reset asserted mid-RESP -> next cycle bus_reqcyc=0, bus_respack=0, instr_valid=0; after release, bus_req=entry & ~63.
